// File: rtl/dig_logic_array.sv
// dig_logic_array: NUM_OUT independently programmable logic channels over a shared,
// registered NUM_IN-bit input bus. Each channel combines its masked inputs with a
// selectable operation and drives a registered output in LEVEL, RISE_PULSE or TOGGLE mode.
//
// Ports:
//   CLK       - system clock, rising edge
//   RST_N     - asynchronous active-low reset (clears data path and configuration)
//   EN        - pipeline advance enable
//   IN        - logic inputs
//   CFG_WE    - configuration write strobe
//   CFG_ADDR  - channel index to write (out-of-range writes are dropped)
//   CFG_MASK  - input select mask, bit i selects IN[i]
//   CFG_OP    - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved (f=0)
//   CFG_MODE  - 0 LEVEL, 1 RISE_PULSE, 2 TOGGLE, 3 behaves as LEVEL
//   OUT       - registered channel outputs
module dig_logic_array #(
    parameter int unsigned NUM_IN  = 5,
    parameter int unsigned NUM_OUT = 3,
    parameter int unsigned AW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               EN,
    input  logic [NUM_IN-1:0]  IN,
    input  logic               CFG_WE,
    input  logic [AW-1:0]      CFG_ADDR,
    input  logic [NUM_IN-1:0]  CFG_MASK,
    input  logic [2:0]         CFG_OP,
    input  logic [1:0]         CFG_MODE,
    output logic [NUM_OUT-1:0] OUT
);

    localparam logic [2:0] OpAnd  = 3'd0;
    localparam logic [2:0] OpOr   = 3'd1;
    localparam logic [2:0] OpXor  = 3'd2;
    localparam logic [2:0] OpNand = 3'd3;
    localparam logic [2:0] OpNor  = 3'd4;
    localparam logic [2:0] OpXnor = 3'd5;

    localparam logic [1:0] ModeRise   = 2'd1;
    localparam logic [1:0] ModeToggle = 2'd2;

    logic [NUM_IN-1:0]  in_d, in_q;
    logic [NUM_OUT-1:0] res_d, res_q;
    logic [NUM_OUT-1:0] out_d, out_q;
    logic [NUM_IN-1:0]  mask_d [NUM_OUT];
    logic [NUM_IN-1:0]  mask_q [NUM_OUT];
    logic [2:0]         op_d   [NUM_OUT];
    logic [2:0]         op_q   [NUM_OUT];
    logic [1:0]         mode_d [NUM_OUT];
    logic [1:0]         mode_q [NUM_OUT];

    logic [NUM_OUT-1:0] func;
    logic [NUM_OUT-1:0] rise;
    logic [NUM_OUT-1:0] wr_sel;
    logic [NUM_IN-1:0]  sel;
    logic               all_one, any_one, parity;

    // Channel functions from the registered inputs and current configuration.
    always_comb begin
        func    = '0;
        sel     = '0;
        all_one = 1'b0;
        any_one = 1'b0;
        parity  = 1'b0;
        for (int c = 0; c < NUM_OUT; c++) begin
            sel     = in_q & mask_q[c];
            // Unselected bits read as 1 for the AND family, 0 for the others.
            all_one = &(in_q | ~mask_q[c]);
            any_one = |sel;
            parity  = ^sel;
            case (op_q[c])
                OpAnd:   func[c] = all_one;
                OpOr:    func[c] = any_one;
                OpXor:   func[c] = parity;
                OpNand:  func[c] = ~all_one;
                OpNor:   func[c] = ~any_one;
                OpXnor:  func[c] = ~parity;
                default: func[c] = 1'b0;
            endcase
            // An empty mask disables the channel regardless of op.
            if (mask_q[c] == '0) begin
                func[c] = 1'b0;
            end
        end
    end

    assign rise = func & ~res_q;

    // Decoding against valid indices only drops out-of-range addresses.
    always_comb begin
        wr_sel = '0;
        for (int c = 0; c < NUM_OUT; c++) begin
            wr_sel[c] = CFG_WE && (CFG_ADDR == AW'(c));
        end
    end

    always_comb begin
        in_d  = EN ? IN : in_q;
        res_d = res_q;
        out_d = out_q;
        for (int c = 0; c < NUM_OUT; c++) begin
            mask_d[c] = mask_q[c];
            op_d[c]   = op_q[c];
            mode_d[c] = mode_q[c];
            if (wr_sel[c]) begin
                // Clearing res_q makes an already-true function produce one rising event.
                mask_d[c] = CFG_MASK;
                op_d[c]   = CFG_OP;
                mode_d[c] = CFG_MODE;
                res_d[c]  = 1'b0;
                out_d[c]  = 1'b0;
            end else if (EN) begin
                res_d[c] = func[c];
                case (mode_q[c])
                    ModeRise:   out_d[c] = rise[c];
                    ModeToggle: out_d[c] = out_q[c] ^ rise[c];
                    default:    out_d[c] = func[c];
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_q  <= '0;
            res_q <= '0;
            out_q <= '0;
            for (int c = 0; c < NUM_OUT; c++) begin
                mask_q[c] <= '0;
                op_q[c]   <= OpAnd;
                mode_q[c] <= 2'd0;
            end
        end else begin
            in_q  <= in_d;
            res_q <= res_d;
            out_q <= out_d;
            for (int c = 0; c < NUM_OUT; c++) begin
                mask_q[c] <= mask_d[c];
                op_q[c]   <= op_d[c];
                mode_q[c] <= mode_d[c];
            end
        end
    end

    assign OUT = out_q;

endmodule

// File: tb/tb_dig_logic_array.sv
// Directed bench for dig_logic_array (NUM_IN=5, NUM_OUT=3). Expected OUT values are
// queued as each step is driven and compared after the following clock edge.
module tb_dig_logic_array;

    localparam int unsigned NI = 5;
    localparam int unsigned NO = 3;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          EN;
    logic [NI-1:0] IN;
    logic          CFG_WE;
    logic [1:0]    CFG_ADDR;
    logic [NI-1:0] CFG_MASK;
    logic [2:0]    CFG_OP;
    logic [1:0]    CFG_MODE;
    logic [NO-1:0] OUT;

    dig_logic_array #(
        .NUM_IN  (NI),
        .NUM_OUT (NO)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .EN       (EN),
        .IN       (IN),
        .CFG_WE   (CFG_WE),
        .CFG_ADDR (CFG_ADDR),
        .CFG_MASK (CFG_MASK),
        .CFG_OP   (CFG_OP),
        .CFG_MODE (CFG_MODE),
        .OUT      (OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string         tag;
        logic [NO-1:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_out(input string tag, input logic [NO-1:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_tests++;
            assert (OUT === x.exp) else begin
                n_fail++;
                $error("FAIL %s: OUT=%b expected %b", x.tag, OUT, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input string tag, input logic [NO-1:0] e);
        expect_out(tag, e);
        tick();
        check_out();
    endtask

    task automatic wr_step(input string tag, input logic [1:0] a, input logic [NI-1:0] m,
                           input logic [2:0] op, input logic [1:0] md,
                           input logic [NO-1:0] e);
        CFG_WE   = 1'b1;
        CFG_ADDR = a;
        CFG_MASK = m;
        CFG_OP   = op;
        CFG_MODE = md;
        step(tag, e);
        CFG_WE   = 1'b0;
    endtask

    // ch1 mask 00110 with IN[2:1]=11: write op, expect clear, then result a cycle later.
    task automatic op_check(input logic [2:0] op, input logic r);
        wr_step($sformatf("op%0d_wr", op), 2'd1, 5'b00110, op, 2'd0, 3'b000);
        step($sformatf("op%0d_res", op), {1'b0, r, 1'b0});
    endtask

    // IN[1] stays high so ch0 (NOR of bits 1:0) remains 0; IN[2] carries the pattern.
    task automatic pat_step(input string tag, input logic p, input logic e2);
        IN = p ? 5'b00110 : 5'b00010;
        step(tag, {e2, 2'b00});
    endtask

    initial begin
        RST_N    = 1'b0;
        EN       = 1'b0;
        IN       = '0;
        CFG_WE   = 1'b0;
        CFG_ADDR = '0;
        CFG_MASK = '0;
        CFG_OP   = '0;
        CFG_MODE = '0;

        #2;
        expect_out("rst_init", 3'b000);
        check_out();
        tick();
        tick();
        RST_N = 1'b1;
        EN    = 1'b1;

        // Default masks are zero: all-ones input leaves every output low.
        IN = 5'b11111;
        step("def0", 3'b000);
        step("def1", 3'b000);
        step("def2", 3'b000);
        step("def3", 3'b000);

        // Latency: ch0 NOR over bits 1:0, LEVEL.
        IN = 5'b00000;
        wr_step("lat_wr", 2'd0, 5'b00011, 3'd4, 2'd0, 3'b000);
        step("lat_pre0", 3'b001);
        step("lat_pre1", 3'b001);
        IN = 5'b00001;
        step("lat_k", 3'b001);
        step("lat_k1", 3'b000);

        // Ops sweep on ch1.
        IN = 5'b00110;
        step("ops_settle", 3'b000);
        op_check(3'd3, 1'b0);
        op_check(3'd0, 1'b1);
        op_check(3'd2, 1'b0);
        op_check(3'd5, 1'b1);
        op_check(3'd1, 1'b1);
        op_check(3'd4, 1'b0);
        op_check(3'd6, 1'b0);

        // RISE_PULSE on ch2, IN[2] pattern 0,1,1,0,1 then held high.
        IN = 5'b00010;
        wr_step("rp_wr", 2'd2, 5'b00100, 3'd1, 2'd1, 3'b000);
        pat_step("rp1", 1'b0, 1'b0);
        pat_step("rp2", 1'b1, 1'b0);
        pat_step("rp3", 1'b1, 1'b1);
        pat_step("rp4", 1'b0, 1'b0);
        pat_step("rp5", 1'b1, 1'b0);
        pat_step("rp6", 1'b1, 1'b1);
        pat_step("rp7", 1'b1, 1'b0);

        // TOGGLE on ch2, same pattern.
        IN = 5'b00010;
        wr_step("tg_wr", 2'd2, 5'b00100, 3'd1, 2'd2, 3'b000);
        pat_step("tg1", 1'b0, 1'b0);
        pat_step("tg2", 1'b1, 1'b0);
        pat_step("tg3", 1'b1, 1'b1);
        pat_step("tg4", 1'b0, 1'b1);
        pat_step("tg5", 1'b1, 1'b1);
        pat_step("tg6", 1'b1, 1'b0);
        pat_step("tg7", 1'b1, 1'b0);

        // EN hold and write-clear priority, ch0 RISE_PULSE on IN[2].
        IN = 5'b00110;
        wr_step("en_wr", 2'd0, 5'b00100, 3'd1, 2'd1, 3'b000);
        step("en_pulse", 3'b001);
        EN = 1'b0;
        IN = 5'b00000;
        step("en_hold1", 3'b001);
        step("en_hold2", 3'b001);
        wr_step("en_wrclr", 2'd0, 5'b00100, 3'd1, 2'd1, 3'b000);
        step("en_hold3", 3'b000);
        EN = 1'b1;
        IN = 5'b00110;
        step("en_one_pulse", 3'b001);
        step("en_after1", 3'b000);
        step("en_after2", 3'b000);

        // Out-of-range address: a misrouted LEVEL/AND write would raise some output.
        wr_step("bad_wr", 2'd3, 5'b00110, 3'd0, 2'd0, 3'b000);
        step("bad_hold1", 3'b000);
        step("bad_hold2", 3'b000);

        // All channels LEVEL, then a ch1 write as ch0/ch2 react to an input change.
        wr_step("sim_w0", 2'd0, 5'b00100, 3'd1, 2'd0, 3'b000);
        wr_step("sim_w1", 2'd1, 5'b00110, 3'd0, 2'd0, 3'b001);
        wr_step("sim_w2", 2'd2, 5'b00100, 3'd1, 2'd0, 3'b011);
        step("sim_all", 3'b111);
        IN = 5'b00000;
        step("sim_in0a", 3'b111);
        step("sim_in0b", 3'b000);
        IN = 5'b00110;
        step("sim_in1", 3'b000);
        wr_step("sim_wr_ch1", 2'd1, 5'b00110, 3'd0, 2'd0, 3'b101);
        step("sim_after", 3'b111);

        // Asynchronous reset mid-cycle with OUT=111, then defaults after release.
        #3;
        RST_N = 1'b0;
        #1;
        expect_out("rst_async", 3'b000);
        check_out();
        tick();
        tick();
        RST_N = 1'b1;
        IN    = 5'b11111;
        step("rst_def0", 3'b000);
        step("rst_def1", 3'b000);
        step("rst_def2", 3'b000);
        step("rst_def3", 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
